phase_request_scheduler: RTL and testbench
==========================================

// Module: phase_request_scheduler
// PURPOSE
//  Collects phase requests from up to NUM_REQ sources (side-street sensor, pedestrian buttons, etc.).
//  Arbitrates round-robin among them and offers one phase grant (id + duration) per handshake to the
//  intersection light controller. Owns the per-requester duration table, enforces a minimum gap
//  between grants and watchdogs each served phase for a missing completion.
// PARAMETERS
//  NUM_REQ        4       number of requesters (2..8); ID_W = $clog2(NUM_REQ)
//  DUR_W          8       width of duration values / counters
//  DEFAULT_DUR    8'd60   reset value of every duration table entry (cycles)
//  MIN_GAP        8'd20   idle cycles enforced after each served phase (0 = no gap)
//  TIMEOUT_MARGIN 8'd16   extra cycles beyond grant_dur before SERVE is declared timed out
// PORTS
//  clk           in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  req_in        in   NUM_REQ  request strobes, one bit per requester (level or pulse)
//  cfg_we        in   1        duration table write enable
//  cfg_idx       in   ID_W     table entry to write
//  cfg_data      in   DUR_W    duration value to write
//  grant_valid   out  1        grant offered
//  grant_ready   in   1        light controller accepts grant
//  grant_id      out  ID_W     requester being granted
//  grant_dur     out  DUR_W    phase length, cycles
//  phase_done    in   1        one-cycle pulse: granted phase finished
//  pending       out  NUM_REQ  latched, not-yet-granted requests
//  busy          out  1        state != IDLE
//  err_timeout   out  1        sticky: a SERVE phase timed out
// BEHAVIOUR
//  Reset (sync, active-high, at clk edge): state=IDLE, pending=0, grant_valid=0, grant_id=0, grant_dur=0,
//   err_timeout=0, rr_ptr=NUM_REQ-1 (first search starts at 0), every table entry=DEFAULT_DUR.
//   Reset mid-operation aborts any offer/serve and clears pending.
//  pending[i] <= pending[i] | req_in[i]; cleared on grant handshake (valid&ready) for i.
//   Set wins when req_in[i] coincides with that clear.
//  FSM: IDLE -> ARB when |pending. ARB (1 cycle): search from rr_ptr+1, wrapping modulo NUM_REQ.
//   First set pending bit is registered into grant_id; grant_dur <= table[id], value 0 clamped to 1. -> OFFER.
//  OFFER: grant_valid=1, grant_id/grant_dur held stable until grant_ready.
//   Handshake: clear pending[id], rr_ptr<=id, load cnt=0 -> SERVE. Grant latency: 2 cycles from pending set.
//  SERVE: cnt increments each cycle. phase_done -> GAP.
//   If cnt reaches grant_dur+TIMEOUT_MARGIN first: set err_timeout -> GAP. Sum is DUR_W+1 bits, no wrap.
//   phase_done on the same cycle as the timeout: done wins, no error.
//  GAP: count MIN_GAP cycles, then -> ARB if |pending, else IDLE. MIN_GAP=0 leaves GAP after 1 cycle.
//  phase_done outside SERVE is ignored. grant_valid is deasserted in every state except OFFER.
//  Config: cfg_we writes table[cfg_idx] at clk; cfg_idx>=NUM_REQ ignored.
//   Write in the same cycle as ARB reads the same entry: ARB uses the old value.
//   An in-flight grant_dur is never altered by a write.
//  err_timeout is cleared only by reset.
// CONFIGURATION
//  PHASE_SCHED_PRIORITY_EN defined: requester 0 is the emergency requester.
//   In ARB, pending[0] beats round-robin; rr_ptr is not updated by a requester-0 grant.
//   In GAP, pending[0] ends the gap immediately (-> ARB).
//  Not defined: pure round-robin, all requesters equal, gap always fully served.
// STRUCTURE
//  phase_sched_pkg: state encoding (IDLE, ARB, OFFER, SERVE, GAP), DUR_W, DEFAULT_DUR, ID_W function.
//  Sub-module rr_arbiter: combinational find-first-set from rr_ptr+1 with wrap.
//   Outputs: found, idx. Priority override applied outside it.
//  Top level holds FSM, counters, pending register and the duration table (register array).
// TESTING
//  1 Reset, req_in=4'b0010 one cycle, grant_ready=1 -> grant_valid 2 cycles later, grant_id=1, grant_dur=60.
//  2 pending=4'b1111, rr_ptr=3, ready always 1, phase_done each SERVE -> grant_id order 0,1,2,3,0.
//    Successive grants separated by >=MIN_GAP=20 cycles.
//  3 cfg write idx=2 data=0, req 2 -> grant_dur=1.
//    Write idx=1 data=9 during ARB for 1 -> grant uses old 60.
//  4 Grant dur=10, no phase_done -> err_timeout set exactly 26 cycles after handshake, FSM enters GAP.
//  5 grant_ready held 0 for 50 cycles -> grant_valid/id/dur stable throughout.
//    New req_in[3] only sets pending[3].
//  6 With PHASE_SCHED_PRIORITY_EN: in GAP with pending=4'b1000, assert req_in[0].
//    -> gap ends, next grant_id=0, then grant_id=3 (rr_ptr unchanged).
//    Without the macro: gap completes, grant_id=3 first.

Source files
------------

// File: rtl/phase_sched_pkg.sv
// Shared types, defaults and helpers for phase_request_scheduler.
package phase_sched_pkg;

    localparam int DUR_W = 8;
    localparam logic [DUR_W-1:0] DEFAULT_DUR            = 8'd60;
    localparam logic [DUR_W-1:0] DEFAULT_MIN_GAP        = 8'd20;
    localparam logic [DUR_W-1:0] DEFAULT_TIMEOUT_MARGIN = 8'd16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        OFFER = 3'd2,
        SERVE = 3'd3,
        GAP   = 3'd4
    } sched_state_t;

    // Width of a requester id; never below one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/phase_request_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request bit strictly after ptr,
// wrapping modulo NUM_REQ, so ptr itself is considered last.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);
    import phase_sched_pkg::*;

    logic [ID_W-1:0] cand;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/phase_request_scheduler.sv
// Phase request scheduler: latches requests, arbitrates round-robin, offers
// one grant (id + duration) per valid/ready handshake, watchdogs each served
// phase and enforces an idle gap between phases.
// Optional build macro PHASE_SCHED_PRIORITY_EN: requester 0 becomes an
// emergency requester that beats round-robin and cuts the gap short.
//
// Handshake: grant_valid is high only in OFFER; grant_id/grant_dur are stable
// while grant_valid is high; a transfer happens on any clk edge where
// grant_valid && grant_ready.
module phase_request_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W = phase_sched_pkg::DUR_W,
    parameter logic [DUR_W-1:0] DEFAULT_DUR = phase_sched_pkg::DEFAULT_DUR,
    parameter logic [DUR_W-1:0] MIN_GAP = phase_sched_pkg::DEFAULT_MIN_GAP,
    parameter logic [DUR_W-1:0] TIMEOUT_MARGIN = phase_sched_pkg::DEFAULT_TIMEOUT_MARGIN,
    localparam int ID_W = phase_sched_pkg::id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               cfg_we,
    input  logic [ID_W-1:0]    cfg_idx,
    input  logic [DUR_W-1:0]   cfg_data,
    output logic               grant_valid,
    input  logic               grant_ready,
    output logic [ID_W-1:0]    grant_id,
    output logic [DUR_W-1:0]   grant_dur,
    input  logic               phase_done,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy,
    output logic               err_timeout
);
    import phase_sched_pkg::*;

    sched_state_t state, state_next;

    logic [DUR_W-1:0]   dur_table [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr;
    // One extra bit so grant_dur + TIMEOUT_MARGIN never wraps.
    logic [DUR_W:0]     serve_cnt, serve_cnt_inc, timeout_limit;
    logic [DUR_W:0]     gap_cnt, gap_cnt_inc;
    logic               arb_found;
    logic [ID_W-1:0]    arb_idx, pick_idx;
    logic [DUR_W-1:0]   pick_dur;
    logic               handshake, serve_timeout, gap_over, gap_urgent;
    logic [NUM_REQ-1:0] clr_mask;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_rr_arbiter (
        .req  (pending),
        .ptr  (rr_ptr),
        .found(arb_found),
        .idx  (arb_idx)
    );

    // Winner of this ARB cycle (with emergency override) and its clamped duration.
    always_comb begin
        pick_idx = arb_idx;
`ifdef PHASE_SCHED_PRIORITY_EN
        if (pending[0]) pick_idx = '0;
`endif
        pick_dur = dur_table[pick_idx];
        if (pick_dur == '0) pick_dur = DUR_W'(1);
    end

`ifdef PHASE_SCHED_PRIORITY_EN
    assign gap_urgent = pending[0];
`else
    assign gap_urgent = 1'b0;
`endif

    assign handshake     = (state == OFFER) && grant_ready;
    assign serve_cnt_inc = serve_cnt + {{DUR_W{1'b0}}, 1'b1};
    assign timeout_limit = {1'b0, grant_dur} + {1'b0, TIMEOUT_MARGIN};
    assign serve_timeout = (serve_cnt_inc >= timeout_limit);
    assign gap_cnt_inc   = gap_cnt + {{DUR_W{1'b0}}, 1'b1};
    assign gap_over      = (gap_cnt_inc >= {1'b0, MIN_GAP});

    assign grant_valid = (state == OFFER);
    assign busy        = (state != IDLE);

    // Pending bit to drop on a completed handshake.
    always_comb begin
        clr_mask = '0;
        if (handshake) clr_mask[grant_id] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = ARB;
            ARB:     state_next = arb_found ? OFFER : IDLE;
            OFFER:   if (grant_ready) state_next = SERVE;
            SERVE:   if (phase_done || serve_timeout) state_next = GAP;
            GAP:     if (gap_urgent || gap_over) state_next = (|pending) ? ARB : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, grant registers, round-robin pointer, counters, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            grant_id    <= '0;
            grant_dur   <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            serve_cnt   <= '0;
            gap_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            // A new request on the clearing cycle survives.
            pending <= (pending & ~clr_mask) | req_in;
            case (state)
                ARB: begin
                    if (arb_found) begin
                        grant_id  <= pick_idx;
                        grant_dur <= pick_dur;
                    end
                end
                OFFER: begin
                    if (grant_ready) begin
                        serve_cnt <= '0;
`ifdef PHASE_SCHED_PRIORITY_EN
                        if (grant_id != '0) rr_ptr <= grant_id;
`else
                        rr_ptr <= grant_id;
`endif
                    end
                end
                SERVE: begin
                    serve_cnt <= serve_cnt_inc;
                    gap_cnt   <= '0;
                    // phase_done on the timeout cycle counts as a clean finish.
                    if (!phase_done && serve_timeout) err_timeout <= 1'b1;
                end
                GAP: begin
                    gap_cnt <= gap_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    // Per-requester duration table; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) dur_table[i] <= DEFAULT_DUR;
        end else if (cfg_we && (int'(cfg_idx) < NUM_REQ)) begin
            dur_table[cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_phase_request_scheduler.sv
// Bench for phase_request_scheduler: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_phase_request_scheduler;

    localparam int MIN_GAP = 20;
    localparam int MARGIN  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_in = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [7:0] cfg_data = '0;
    logic       grant_ready = 1'b0;
    logic       phase_done = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [7:0] grant_dur;
    logic [3:0] pending;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [1:0] exp_q[$];

    phase_request_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (req_in),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_data   (cfg_data),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .grant_id   (grant_id),
        .grant_dur  (grant_dur),
        .phase_done (phase_done),
        .pending    (pending),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    // Clock.
    always #5 clk = ~clk;

    // Absolute time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic [3:0] r, input logic rdy, input logic done);
        req_in      = r;
        grant_ready = rdy;
        phase_done  = done;
        @(posedge clk);
        #1;
        cyc_n++;
        req_in     = '0;
        phase_done = 1'b0;
        cfg_we     = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = data;
        cyc('0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_id",    32'(grant_id),    32'd0);
        check("rst_dur",   32'(grant_dur),   32'd0);
        check("rst_pend",  32'(pending),     32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_err",   32'(err_timeout), 32'd0);
    endtask

    // Wait (bounded) for grant_valid; waited = cycles spent.
    task automatic wait_valid(input string name, input logic rdy, input int max, output int waited);
        waited = 0;
        while (!grant_valid && waited < max) begin
            cyc('0, rdy, 1'b0);
            waited++;
        end
        if (!grant_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: got no grant_valid expected grant within %0d cycles", name, max);
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            cyc('0, 1'b0, 1'b0);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Reference arbitration: first pending bit after last, emergency first if enabled.
    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
        logic [1:0] c;
        rr_pick = '0;
        for (int k = 4; k >= 1; k--) begin
            c = last + 2'(k);
            if (p[c]) rr_pick = c;
        end
`ifdef PHASE_SCHED_PRIORITY_EN
        if (p[0]) rr_pick = 2'd0;
`endif
    endfunction

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       done;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [7:0] exp_dur;
        logic [3:0] exp_pend;
        logic       exp_busy;
    } vec_t;

    vec_t vt[8];

    // Random-run model state.
    logic [3:0] pend_m, prev_pend;
    logic [7:0] tab_m [4];
    logic [7:0] prev_tab [4];
    logic [1:0] last_m, cur_id;
    logic [7:0] cur_dur;
    logic       in_serve, err_m, have_end, pre_valid, hs;
    int         serve_k, lim, end_n;
    logic [3:0] r_req;
    logic       r_rdy, r_done, r_we;
    logic [1:0] r_idx;
    logic [7:0] r_data;

    initial begin
        int w, rise_prev, rise_now;
        logic [1:0] eid;

        // ---------------- vector table ----------------
        vt[0] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  4'b0000, 1'b0};
        vt[1] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  4'b0010, 1'b0};
        vt[2] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0,  4'b0010, 1'b1};
        vt[3] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 8'd60, 4'b0010, 1'b1};
        vt[4] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd1, 8'd60, 4'b0010, 1'b1};
        vt[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 8'd60, 4'b0010, 1'b1};
        vt[6] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 8'd60, 4'b0010, 1'b1};
        vt[7] = '{4'b1000, 1'b0, 1'b0, 1'b0, 2'd1, 8'd60, 4'b1010, 1'b1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].req, vt[i].rdy, vt[i].done);
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vt[i].exp_valid));
            check($sformatf("vec%0d_id", i),    32'(grant_id),    32'(vt[i].exp_id));
            check($sformatf("vec%0d_dur", i),   32'(grant_dur),   32'(vt[i].exp_dur));
            check($sformatf("vec%0d_pend", i),  32'(pending),     32'(vt[i].exp_pend));
            check($sformatf("vec%0d_busy", i),  32'(busy),        32'(vt[i].exp_busy));
        end

        // ---------------- round-robin order and gap spacing ----------------
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        cyc(4'b1111, 1'b1, 1'b0);
        rise_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_valid($sformatf("rr_wait%0d", g), 1'b1, 60, w);
            rise_now = cyc_n;
            eid = exp_q.pop_front();
            check($sformatf("rr_id%0d", g), 32'(grant_id), 32'(eid));
            if (g == 4) begin
`ifdef PHASE_SCHED_PRIORITY_EN
                check("rr_spacing4", 32'(rise_now - rise_prev), 32'd4);
`else
                check("rr_spacing4", 32'(rise_now - rise_prev), 32'(MIN_GAP + 3));
`endif
            end else if (g > 0) begin
                check($sformatf("rr_spacing%0d", g), 32'(rise_now - rise_prev), 32'(MIN_GAP + 3));
            end
            rise_prev = rise_now;
            cyc((g == 3) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            cyc('0, 1'b1, 1'b1);
        end
        wait_idle("rr_idle", 60);

        // ---------------- duration table: zero clamp, write during ARB ----------------
        do_reset();
        cfg_write(2'd2, 8'd0);
        cyc(4'b0100, 1'b0, 1'b0);
        wait_valid("cfg_wait0", 1'b0, 10, w);
        check("cfg_zero_id",  32'(grant_id),  32'd2);
        check("cfg_zero_dur", 32'(grant_dur), 32'd1);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);
        wait_idle("cfg_idle0", 60);
        cyc(4'b0010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cfg_write(2'd1, 8'd9);
        check("cfg_arb_valid", 32'(grant_valid), 32'd1);
        check("cfg_arb_id",    32'(grant_id),    32'd1);
        check("cfg_arb_old",   32'(grant_dur),   32'd60);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);
        wait_idle("cfg_idle1", 60);
        cyc(4'b0010, 1'b0, 1'b0);
        wait_valid("cfg_wait2", 1'b0, 10, w);
        check("cfg_new_dur", 32'(grant_dur), 32'd9);

        // ---------------- serve timeout ----------------
        do_reset();
        cfg_write(2'd0, 8'd10);
        cyc(4'b0001, 1'b0, 1'b0);
        wait_valid("to_wait", 1'b0, 10, w);
        cyc('0, 1'b1, 1'b0);
        for (int k = 1; k <= 25; k++) cyc('0, 1'b0, 1'b0);
        check("to_err_before", 32'(err_timeout), 32'd0);
        cyc('0, 1'b0, 1'b0);
        check("to_err_at26",   32'(err_timeout), 32'd1);
        check("to_gap_busy",   32'(busy),        32'd1);
        check("to_gap_valid",  32'(grant_valid), 32'd0);
        for (int k = 1; k <= 19; k++) cyc('0, 1'b0, (k == 5));
        check("to_gap_end_busy", 32'(busy), 32'd1);
        cyc('0, 1'b0, 1'b0);
        check("to_idle",       32'(busy),        32'd0);
        check("to_err_sticky", 32'(err_timeout), 32'd1);

        // phase_done on the timeout cycle wins
        do_reset();
        cfg_write(2'd0, 8'd10);
        cyc(4'b0001, 1'b0, 1'b0);
        wait_valid("tod_wait", 1'b0, 10, w);
        cyc('0, 1'b1, 1'b0);
        for (int k = 1; k <= 25; k++) cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        check("tod_no_err", 32'(err_timeout), 32'd0);
        check("tod_busy",   32'(busy),        32'd1);

        // ---------------- held offer ----------------
        do_reset();
        cyc(4'b0100, 1'b0, 1'b0);
        wait_valid("hold_wait", 1'b0, 10, w);
        for (int k = 0; k < 50; k++) begin
            cyc((k == 10) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            check($sformatf("hold%0d", k), {29'd0, grant_valid, grant_id}, {29'd0, 1'b1, 2'd2});
            check($sformatf("hold_dur%0d", k), 32'(grant_dur), 32'd60);
        end
        check("hold_pend", 32'(pending), 32'b1100);
        cyc('0, 1'b1, 1'b0);
        check("hold_pend_after", 32'(pending), 32'b1000);
        check("hold_valid_after", 32'(grant_valid), 32'd0);

        // ---------------- emergency requester in GAP ----------------
        do_reset();
        cyc(4'b0010, 1'b0, 1'b0);
        wait_valid("emg_wait0", 1'b0, 10, w);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0);
        wait_valid("emg_wait1", 1'b0, 40, w);
`ifdef PHASE_SCHED_PRIORITY_EN
        check("emg_wait_len", 32'(w), 32'd2);
        check("emg_first_id", 32'(grant_id), 32'd0);
`else
        check("emg_wait_len", 32'(w), 32'(MIN_GAP - 1));
        check("emg_first_id", 32'(grant_id), 32'd3);
`endif
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);
        wait_valid("emg_wait2", 1'b0, 40, w);
`ifdef PHASE_SCHED_PRIORITY_EN
        check("emg_second_id", 32'(grant_id), 32'd3);
`else
        check("emg_second_id", 32'(grant_id), 32'd0);
`endif

        // ---------------- randomized run against reference model ----------------
        do_reset();
        pend_m = '0;
        for (int i = 0; i < 4; i++) tab_m[i] = 8'd60;
        last_m = 2'd3;
        cur_id = '0;
        cur_dur = '0;
        in_serve = 1'b0;
        err_m = 1'b0;
        have_end = 1'b0;
        serve_k = 0;
        lim = 0;
        end_n = 0;
        for (int n = 0; n < 3000; n++) begin
            r_req  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            r_rdy  = 1'($urandom_range(0, 1));
            r_done = in_serve ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 39) == 0);
            r_we   = ($urandom_range(0, 14) == 0);
            r_idx  = 2'($urandom_range(0, 3));
            r_data = 8'($urandom_range(0, 24));
            pre_valid = grant_valid;
            cfg_we   = r_we;
            cfg_idx  = r_idx;
            cfg_data = r_data;
            cyc(r_req, r_rdy, r_done);

            hs = pre_valid & r_rdy;
            if (in_serve) begin
                serve_k++;
                if (r_done) begin
                    in_serve = 1'b0; end_n = n; have_end = 1'b1;
                end else if (serve_k >= lim) begin
                    err_m = 1'b1; in_serve = 1'b0; end_n = n; have_end = 1'b1;
                end
            end
            prev_pend = pend_m;
            prev_tab  = tab_m;
            if (hs) begin
                pend_m   = pend_m & ~(4'b0001 << cur_id);
                in_serve = 1'b1;
                serve_k  = 0;
                lim      = int'(cur_dur) + MARGIN;
`ifdef PHASE_SCHED_PRIORITY_EN
                if (cur_id != 2'd0) last_m = cur_id;
`else
                last_m = cur_id;
`endif
            end
            pend_m = pend_m | r_req;
            if (r_we) tab_m[r_idx] = r_data;

            check("rand_pend", 32'(pending),     32'(pend_m));
            check("rand_err",  32'(err_timeout), 32'(err_m));
            if (grant_valid && !pre_valid) begin
                check("rand_arb_nonempty", 32'(|prev_pend), 32'd1);
                cur_id  = rr_pick(prev_pend, last_m);
                cur_dur = (prev_tab[cur_id] == 8'd0) ? 8'd1 : prev_tab[cur_id];
                check("rand_id",  32'(grant_id),  32'(cur_id));
                check("rand_dur", 32'(grant_dur), 32'(cur_dur));
`ifndef PHASE_SCHED_PRIORITY_EN
                if (have_end) check("rand_gap_ok", 32'((n - end_n) >= MIN_GAP + 1), 32'd1);
`endif
            end else if (grant_valid) begin
                check("rand_hold", {22'd0, grant_id, grant_dur}, {22'd0, cur_id, cur_dur});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
